bp_update_ctrl: RTL and testbench

//  Scheduler between the two execute branch units and the prediction stage.

---
 rtl/bp_update_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_bp_update_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// Branch-resolution scheduler: queues resolved branches from two execute ports and drains one per cycle to the PHT/BTB update port; sequences mispredict recovery.
// Latency: a pushed record reaches the update port one cycle later at the earliest (empty-queue bypass into the output registers); recovery starts the cycle after the push.
// Backpressure: ex_ready drops when fewer than two entries are free; the predictor side never stalls the drain.
//
// Ports:
//   CLK, reset                 clock (rising edge), asynchronous active-high reset
//   ex0_* / ex1_*              resolved-branch records; ex0 is older in program order
//   ex_ready                   both ports may push this cycle
//   update_pht / update_btb    write strobes for the head record
//   actual_taken, rb_pht_index, ex_pc, actual_target_address, ex_is_ret, ex_is_branch
//                              head-record data, held while no strobe is active
//   restore_ghr, ghr_restore_val, redirect_valid, redirect_pc, fetch_stall
//                              recovery outputs
//   queue_count                queue occupancy
module bp_update_ctrl #(
    parameter int XLEN         = 32,
    parameter int PHT_ADDRESS  = 9,
    parameter int QDEPTH       = 8,
    parameter int STALL_CYCLES = 3
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     ex0_valid,
    input  logic [XLEN-1:0]          ex0_pc,
    input  logic                     ex0_taken,
    input  logic [XLEN-1:0]          ex0_target,
    input  logic                     ex0_is_branch,
    input  logic                     ex0_is_ret,
    input  logic [PHT_ADDRESS-1:0]   ex0_pht_idx,
    input  logic [PHT_ADDRESS-1:0]   ex0_ghr_snap,
    input  logic                     ex0_mispred,
    input  logic                     ex1_valid,
    input  logic [XLEN-1:0]          ex1_pc,
    input  logic                     ex1_taken,
    input  logic [XLEN-1:0]          ex1_target,
    input  logic                     ex1_is_branch,
    input  logic                     ex1_is_ret,
    input  logic [PHT_ADDRESS-1:0]   ex1_pht_idx,
    input  logic [PHT_ADDRESS-1:0]   ex1_ghr_snap,
    input  logic                     ex1_mispred,
    output logic                     ex_ready,
    output logic                     update_pht,
    output logic                     update_btb,
    output logic                     actual_taken,
    output logic [PHT_ADDRESS-1:0]   rb_pht_index,
    output logic [XLEN-1:0]          ex_pc,
    output logic [XLEN-1:0]          actual_target_address,
    output logic                     ex_is_ret,
    output logic                     ex_is_branch,
    output logic                     restore_ghr,
    output logic [PHT_ADDRESS-1:0]   ghr_restore_val,
    output logic                     redirect_valid,
    output logic [XLEN-1:0]          redirect_pc,
    output logic                     fetch_stall,
    output logic [$clog2(QDEPTH):0]  queue_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STALL_CYCLES + 1);

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        target;
        logic [PHT_ADDRESS-1:0] idx;
        logic                   taken;
        logic                   is_branch;
        logic                   is_ret;
    } rec_t;

    typedef enum logic [1:0] {IDLE, REDIRECT, STALL} state_t;

    // ---------------------------------------------------------------- queue
    rec_t           mem [QDEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    rec_t           rec0;
    rec_t           rec1;
    rec_t           src;
    logic           src_vld;
    logic           push0;
    logic           push1;
    logic           enq0;
    logic           enq1;
    logic           empty;
    logic           pop;

    assign rec0 = '{pc: ex0_pc, target: ex0_target, idx: ex0_pht_idx,
                    taken: ex0_taken, is_branch: ex0_is_branch, is_ret: ex0_is_ret};
    assign rec1 = '{pc: ex1_pc, target: ex1_target, idx: ex1_pht_idx,
                    taken: ex1_taken, is_branch: ex1_is_branch, is_ret: ex1_is_ret};

    // Gated with reset so every output, ex_ready included, reads 0 while reset is held.
    assign ex_ready    = ~reset & (count <= CW'(QDEPTH - 2));
    assign push0       = ex0_valid & ex_ready;
    assign push1       = ex1_valid & ex_ready;
    assign empty       = (count == '0);
    assign pop         = ~empty;
    assign queue_count = count;

    // With an empty queue the oldest pushed record bypasses storage and goes
    // straight into the output registers; anything younger is enqueued.
    always_comb begin
        src     = mem[rd_ptr];
        src_vld = 1'b0;
        enq0    = push0;
        enq1    = push1;
        if (!empty) begin
            src_vld = 1'b1;
        end else if (push0) begin
            src     = rec0;
            src_vld = 1'b1;
            enq0    = 1'b0;
        end else if (push1) begin
            src     = rec1;
            src_vld = 1'b1;
            enq1    = 1'b0;
        end
    end

    // Storage needs no reset: validity is tracked entirely by count.
    always_ff @(posedge CLK) begin
        if (enq0) mem[wr_ptr] <= rec0;
        if (enq1) mem[wr_ptr + PW'(enq0)] <= rec1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(enq0) + PW'(enq1);
            count  <= count + CW'(enq0) + CW'(enq1) - CW'(pop);
        end
    end

    // ---------------------------------------------------------- update port
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            update_pht            <= 1'b0;
            update_btb            <= 1'b0;
            actual_taken          <= 1'b0;
            rb_pht_index          <= '0;
            ex_pc                 <= '0;
            actual_target_address <= '0;
            ex_is_ret             <= 1'b0;
            ex_is_branch          <= 1'b0;
        end else begin
            update_pht <= src_vld & src.is_branch;
            update_btb <= src_vld & (src.taken | src.is_ret);
            // Data only moves when some strobe fires for this record.
            if (src_vld && (src.is_branch || src.taken || src.is_ret)) begin
                actual_taken          <= src.taken;
                rb_pht_index          <= src.idx;
                ex_pc                 <= src.pc;
                actual_target_address <= src.target;
                ex_is_ret             <= src.is_ret;
                ex_is_branch          <= src.is_branch;
            end
        end
    end

    // ------------------------------------------------------- recovery FSM
    state_t                 state_q, state_d;
    logic [SW-1:0]          cnt_q, cnt_d;
    logic [XLEN-1:0]        rpc_q, rpc_d;
    logic [PHT_ADDRESS-1:0] rghr_q, rghr_d;

    logic                   mp0;
    logic                   mp1;

    assign mp0 = push0 & ex0_mispred;
    assign mp1 = push1 & ex1_mispred;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rpc_q   <= '0;
            rghr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpc_q   <= rpc_d;
            rghr_q  <= rghr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpc_d   = rpc_q;
        rghr_d  = rghr_q;
        case (state_q)
            REDIRECT: begin
                state_d = STALL;
                cnt_d   = SW'(STALL_CYCLES);
            end
            STALL: begin
                if (cnt_q == SW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            default: ;
        endcase
        // A new mispredict restarts recovery from any state; ex0 is older and wins.
        if (mp0) begin
            state_d = REDIRECT;
            cnt_d   = SW'(STALL_CYCLES);
            rpc_d   = ex0_taken ? ex0_target : ex0_pc + XLEN'(4);
            rghr_d  = {ex0_ghr_snap[PHT_ADDRESS-2:0],
                       ex0_is_branch ? ex0_taken : ex0_ghr_snap[0]};
        end else if (mp1) begin
            state_d = REDIRECT;
            cnt_d   = SW'(STALL_CYCLES);
            rpc_d   = ex1_taken ? ex1_target : ex1_pc + XLEN'(4);
            rghr_d  = {ex1_ghr_snap[PHT_ADDRESS-2:0],
                       ex1_is_branch ? ex1_taken : ex1_ghr_snap[0]};
        end
    end

    assign restore_ghr     = (state_q == REDIRECT);
    assign redirect_valid  = (state_q == REDIRECT);
    assign fetch_stall     = (state_q != IDLE);
    assign redirect_pc     = rpc_q;
    assign ghr_restore_val = rghr_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;

    logic        CLK;
    logic        reset;
    logic        ex0_valid, ex1_valid;
    logic [31:0] ex0_pc, ex1_pc, ex0_target, ex1_target;
    logic        ex0_taken, ex1_taken, ex0_is_branch, ex1_is_branch;
    logic        ex0_is_ret, ex1_is_ret, ex0_mispred, ex1_mispred;
    logic [8:0]  ex0_pht_idx, ex1_pht_idx, ex0_ghr_snap, ex1_ghr_snap;
    logic        ex_ready, update_pht, update_btb, actual_taken;
    logic [8:0]  rb_pht_index, ghr_restore_val;
    logic [31:0] ex_pc, actual_target_address, redirect_pc;
    logic        ex_is_ret, ex_is_branch, restore_ghr, redirect_valid, fetch_stall;
    logic [3:0]  queue_count;

    int tests = 0;
    int fails = 0;

    bp_update_ctrl dut (
        .CLK(CLK), .reset(reset),
        .ex0_valid(ex0_valid), .ex0_pc(ex0_pc), .ex0_taken(ex0_taken), .ex0_target(ex0_target),
        .ex0_is_branch(ex0_is_branch), .ex0_is_ret(ex0_is_ret), .ex0_pht_idx(ex0_pht_idx),
        .ex0_ghr_snap(ex0_ghr_snap), .ex0_mispred(ex0_mispred),
        .ex1_valid(ex1_valid), .ex1_pc(ex1_pc), .ex1_taken(ex1_taken), .ex1_target(ex1_target),
        .ex1_is_branch(ex1_is_branch), .ex1_is_ret(ex1_is_ret), .ex1_pht_idx(ex1_pht_idx),
        .ex1_ghr_snap(ex1_ghr_snap), .ex1_mispred(ex1_mispred),
        .ex_ready(ex_ready), .update_pht(update_pht), .update_btb(update_btb),
        .actual_taken(actual_taken), .rb_pht_index(rb_pht_index), .ex_pc(ex_pc),
        .actual_target_address(actual_target_address), .ex_is_ret(ex_is_ret),
        .ex_is_branch(ex_is_branch), .restore_ghr(restore_ghr),
        .ghr_restore_val(ghr_restore_val), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_stall(fetch_stall), .queue_count(queue_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic br, input logic rt, input logic [8:0] idx,
                          input logic [8:0] snap, input logic mp);
        ex0_valid = v; ex0_pc = pc; ex0_taken = tk; ex0_target = tgt;
        ex0_is_branch = br; ex0_is_ret = rt; ex0_pht_idx = idx; ex0_ghr_snap = snap; ex0_mispred = mp;
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic br, input logic rt, input logic [8:0] idx,
                          input logic [8:0] snap, input logic mp);
        ex1_valid = v; ex1_pc = pc; ex1_taken = tk; ex1_target = tgt;
        ex1_is_branch = br; ex1_is_ret = rt; ex1_pht_idx = idx; ex1_ghr_snap = snap; ex1_mispred = mp;
    endtask

    task automatic idle_inputs();
        drive0(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_ready"},    ex_ready, 0);
        chk({tag, "_update_pht"},  update_pht, 0);
        chk({tag, "_update_btb"},  update_btb, 0);
        chk({tag, "_taken"},       actual_taken, 0);
        chk({tag, "_pht_idx"},     rb_pht_index, 0);
        chk({tag, "_ex_pc"},       ex_pc, 0);
        chk({tag, "_target"},      actual_target_address, 0);
        chk({tag, "_is_ret"},      ex_is_ret, 0);
        chk({tag, "_is_branch"},   ex_is_branch, 0);
        chk({tag, "_restore_ghr"}, restore_ghr, 0);
        chk({tag, "_ghr_val"},     ghr_restore_val, 0);
        chk({tag, "_redir_vld"},   redirect_valid, 0);
        chk({tag, "_redir_pc"},    redirect_pc, 0);
        chk({tag, "_stall"},       fetch_stall, 0);
        chk({tag, "_count"},       queue_count, 0);
    endtask

    initial begin
        int  nxt;
        int  popped;
        int  mcnt;
        logic exp_rdy;

        reset = 1'b1;
        idle_inputs();
        step();
        step();
        chk_all_zero("rst");
        reset = 1'b0;
        #1;
        chk("rst_ready_after", ex_ready, 1);

        // T1: single taken branch through the bypass path
        drive0(1, 32'h100, 1, 32'h200, 1, 0, 9'h005, 9'h000, 0);
        step();
        idle_inputs();
        chk("t1_update_pht", update_pht, 1);
        chk("t1_update_btb", update_btb, 1);
        chk("t1_ex_pc", ex_pc, 32'h100);
        chk("t1_target", actual_target_address, 32'h200);
        chk("t1_taken", actual_taken, 1);
        chk("t1_pht_idx", rb_pht_index, 9'h005);
        chk("t1_is_branch", ex_is_branch, 1);
        chk("t1_count", queue_count, 0);
        step();
        chk("t1_pht_off", update_pht, 0);
        chk("t1_btb_off", update_btb, 0);
        chk("t1_pc_hold", ex_pc, 32'h100);

        // T2: dual push drains in program order
        drive0(1, 32'h10, 0, 32'h0,  1, 0, 9'h001, 9'h000, 0);
        drive1(1, 32'h14, 1, 32'h80, 1, 0, 9'h002, 9'h000, 0);
        step();
        idle_inputs();
        chk("t2_first_pc", ex_pc, 32'h10);
        chk("t2_first_pht", update_pht, 1);
        chk("t2_first_btb", update_btb, 0);
        chk("t2_count1", queue_count, 1);
        step();
        chk("t2_second_pc", ex_pc, 32'h14);
        chk("t2_second_btb", update_btb, 1);
        chk("t2_second_tgt", actual_target_address, 32'h80);
        chk("t2_second_idx", rb_pht_index, 9'h002);
        chk("t2_count0", queue_count, 0);

        // T3: both ports push every cycle until ex_ready drops at 7 entries
        nxt = 0; popped = 0; mcnt = 0;
        for (int c = 0; c < 10; c++) begin
            exp_rdy = (mcnt <= 6);
            chk("t3_ready", ex_ready, exp_rdy);
            drive0(1, 32'h1000 + 4 * nxt,       0, 0, 1, 0, 9'h010, 0, 0);
            drive1(1, 32'h1000 + 4 * (nxt + 1), 0, 0, 1, 0, 9'h011, 0, 0);
            step();
            if (exp_rdy) begin
                nxt  += 2;
                mcnt += 1;
            end else begin
                mcnt -= 1;
            end
            chk("t3_count", queue_count, mcnt);
            chk("t3_pop_pc", ex_pc, 32'h1000 + 4 * popped);
            chk("t3_pop_pht", update_pht, 1);
            popped++;
        end
        idle_inputs();
        while (mcnt > 0) begin
            step();
            mcnt--;
            chk("t3_drain_pc", ex_pc, 32'h1000 + 4 * popped);
            chk("t3_drain_count", queue_count, mcnt);
            popped++;
        end
        step();
        chk("t3_drained_pht", update_pht, 0);
        chk("t3_drained_pc", ex_pc, 32'h1000 + 4 * (nxt - 1));

        // T4: not-taken mispredict, stall covers redirect + 3 cycles
        drive0(1, 32'h40, 0, 32'h999, 1, 0, 9'h003, 9'h0AA, 1);
        step();
        idle_inputs();
        chk("t4_restore", restore_ghr, 1);
        chk("t4_redir_vld", redirect_valid, 1);
        chk("t4_redir_pc", redirect_pc, 32'h44);
        chk("t4_ghr_val", ghr_restore_val, 9'h154);
        chk("t4_stall0", fetch_stall, 1);
        chk("t4_upd_btb", update_btb, 0);
        step();
        chk("t4_restore_off", restore_ghr, 0);
        chk("t4_redir_off", redirect_valid, 0);
        chk("t4_stall1", fetch_stall, 1);
        step();
        chk("t4_stall2", fetch_stall, 1);
        step();
        chk("t4_stall3", fetch_stall, 1);
        step();
        chk("t4_stall_end", fetch_stall, 0);

        // T5: dual mispredict (ex0 wins), then re-mispredict during STALL
        drive0(1, 32'h50, 1, 32'h300, 1, 0, 9'h004, 9'h1FF, 1);
        drive1(1, 32'h54, 1, 32'h500, 1, 0, 9'h005, 9'h000, 1);
        step();
        idle_inputs();
        chk("t5_redir_vld", redirect_valid, 1);
        chk("t5_redir_pc", redirect_pc, 32'h300);
        chk("t5_ghr_val", ghr_restore_val, 9'h1FF);
        chk("t5_head_pc", ex_pc, 32'h50);
        step();
        chk("t5_stall_a", fetch_stall, 1);
        chk("t5_redir_off", redirect_valid, 0);
        chk("t5_ex1_drained", ex_pc, 32'h54);
        chk("t5_ex1_btb", update_btb, 1);
        step();
        chk("t5_stall_b", fetch_stall, 1);
        drive0(1, 32'h60, 0, 32'h0, 0, 0, 9'h006, 9'h101, 1);
        step();
        idle_inputs();
        chk("t5_redir2_vld", redirect_valid, 1);
        chk("t5_redir2_pc", redirect_pc, 32'h64);
        chk("t5_ghr2_val", ghr_restore_val, 9'h003);
        chk("t5_no_strobe", update_pht, 0);
        chk("t5_data_hold", ex_pc, 32'h54);
        step();
        chk("t5_restart1", fetch_stall, 1);
        step();
        chk("t5_restart2", fetch_stall, 1);
        step();
        chk("t5_restart3", fetch_stall, 1);
        step();
        chk("t5_restart_end", fetch_stall, 0);

        // T6: asynchronous reset with 5 queued entries during STALL
        for (int c = 0; c < 5; c++) begin
            drive0(1, 32'h3000 + 8 * c, 1, 32'h4000, 1, 0, 9'h007, 9'h000, (c == 3));
            drive1(1, 32'h3004 + 8 * c, 1, 32'h4000, 1, 0, 9'h008, 9'h000, 0);
            step();
        end
        idle_inputs();
        chk("t6_count5", queue_count, 5);
        chk("t6_in_stall", fetch_stall, 1);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("t6_async");
        #1;
        reset = 1'b0;
        step();
        chk("t6_count_after", queue_count, 0);
        chk("t6_pht_after", update_pht, 0);
        chk("t6_stall_after", fetch_stall, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
